sparc_preload_sequencer: RTL and testbench
==========================================

# sparc_preload_sequencer

- Synthesizable, parametrised replacement for the hand-written preload-and-run sequence in our core bench.
- Copies a program image of `WORDS` words from a read-only source port into the datapath RAM through the MFA/MFC memory handshake.
- Holds the CU/datapath in reset while loading, then releases it and counts a bounded run window.
- Sits between the image source (ROM or bench model) and the datapath RAM port; drives the core reset.

## Interface
Parameters:
- `DATA_W`, 32, word width of image and RAM data.
- `ADDR_W`, 8, word-index width of the image source; `WORDS` ≤ 2^`ADDR_W`.
- `WORDS`, 64, number of words to load, ≥1.
- `RUN_CYCLES`, 100, core clock cycles to run after reset release, ≥1.
- `MFC_TIMEOUT`, 15, maximum cycles MFA may stay high without MFC, ≥1.
- `RST_HOLD`, 2, extra cycles `core_reset_n` stays low after the last write, ≥1.

Ports:
- `Clk`  in  1  clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load/run sequence.
- `src_addr`  out  ADDR_W  word index presented to the image source.
- `src_data`  in  DATA_W  image word; valid the cycle after `src_addr` changes.
- `mem_addr`  out  ADDR_W+2  RAM byte address = word index × 4.
- `mem_wdata`  out  DATA_W  RAM write data.
- `MFA`  out  1  memory function active (write request).
- `MFC`  in  1  memory function complete.
- `core_reset_n`  out  1  active-low reset to CU/datapath.
- `busy`  out  1  sequence in progress.
- `done`  out  1  run window completed.
- `err`  out  1  handshake timeout or checksum mismatch.
- `cycles`  out  16  run cycles elapsed; saturates at 16'hFFFF.
- `expected_sum`  in  DATA_W  reference image checksum; ignored without the macro.

## Operation
- States: IDLE, FETCH, WRITE, ACKLOW, HOLD, RUN, DONE, ERROR.
- IDLE: all strobes low, `core_reset_n`=0. `start` → FETCH with word index 0, checksum 0, `cycles` 0.
- FETCH (1 cycle): `src_addr`=index → WRITE; `mem_wdata` latches `src_data` on entry to WRITE.
- WRITE: `MFA`=1, `mem_addr`=index×4. MFC sampled 1 → ACKLOW. Timeout counter reaching `MFC_TIMEOUT` → ERROR.
- ACKLOW: `MFA`=0; wait for MFC=0.
  - If the index is not the last, increment it → FETCH.
  - At index `WORDS`-1 → HOLD.
  - Timeout counter is reused here: MFC stuck high for `MFC_TIMEOUT` cycles → ERROR.
- HOLD: `core_reset_n`=0 for `RST_HOLD` cycles, then → RUN.
- RUN: `core_reset_n`=1; `cycles` increments every clock. At `cycles`=`RUN_CYCLES` → DONE.
- DONE: `done`=1, `core_reset_n` stays 1, `cycles` keeps counting (saturating).
- ERROR: `err`=1, `MFA`=0, `core_reset_n`=0.
- `start` is ignored while `busy`. `start` in DONE/ERROR clears `done`/`err` and restarts from FETCH.
- `busy` = state ∈ {FETCH, WRITE, ACKLOW, HOLD, RUN}.

## Timing
- Reset values: state IDLE, `src_addr`=0, `mem_addr`=0, `mem_wdata`=0, `MFA`=0, `core_reset_n`=0, `busy`=0, `done`=0, `err`=0, `cycles`=0.
- All outputs are registered.
- Minimum per word is 3 cycles (FETCH, WRITE with MFC on first cycle, ACKLOW with MFC already low).
- Minimum total from `start` to `core_reset_n`=1 is 1 + 3×`WORDS` + `RST_HOLD` cycles.
- `MFA` never rises in the same cycle MFC is high.
- Reset asserted mid-sequence aborts immediately: `MFA` drops asynchronously and the core is held in reset.
- MFC high while in IDLE, HOLD or RUN is ignored.

## Configuration
- `PRELOAD_CHECKSUM_EN` defined:
  - A `DATA_W`-bit modular sum of all written words accumulates on each accepted MFC.
  - Entering HOLD, sum ≠ `expected_sum` → ERROR instead of HOLD.
- Undefined: no accumulator; `expected_sum` unused; ACKLOW at the last word always → HOLD.

## Test plan
- `WORDS`=4, source words 32'h9C044012.., MFC responds after 1 cycle → RAM bytes 0..15 hold the image; `core_reset_n` rises at cycle 1+4×4+2; `done` after a further 100 cycles.
- MFC held low forever → `err`=1 exactly `MFC_TIMEOUT` cycles after `MFA` rises; `MFA`=0, `core_reset_n`=0.
- MFC stuck high after ack → ERROR from ACKLOW; `MFA` never re-asserts.
- `Reset` pulsed low during WRITE of word 2 → all outputs at reset values; next `start` reloads from word 0.
- `start` pulsed during RUN → ignored, `cycles` uninterrupted. `start` in DONE → clean reload with `done`=0.
- With `PRELOAD_CHECKSUM_EN`: `expected_sum` correct → RUN; off by 1 → `err`=1, core held in reset.

Source files
------------

// File: rtl/sparc_preload_sequencer.sv
// Preloads a WORDS-word program image into the datapath RAM over MFA/MFC, then releases the
// core reset for a bounded run window. Define PRELOAD_CHECKSUM_EN to verify the image sum.
module sparc_preload_sequencer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WORDS       = 64,
  parameter int unsigned RUN_CYCLES  = 100,
  parameter int unsigned MFC_TIMEOUT = 15,
  parameter int unsigned RST_HOLD    = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              MFA,
  input  logic              MFC,
  output logic              core_reset_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       cycles,
  input  logic [DATA_W-1:0] expected_sum
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWrite, StAckLow, StHold, StRun, StDone, StError
  } state_e;

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_idx, w_idx_next;
  logic [ADDR_W+1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_wdata, w_wdata_next;
  logic [15:0]       r_tmo, w_tmo_next;
  logic [15:0]       r_hold, w_hold_next;
  logic [15:0]       r_cycles, w_cycles_next, w_cyc_inc;
  logic              r_mfa, r_core_rst_n, r_busy, r_done, r_err;
  logic              w_launch, w_last, w_sum_ok;

  assign w_launch  = start && !r_busy;
  assign w_last    = (r_idx == ADDR_W'(WORDS - 1));
  assign w_cyc_inc = (r_cycles == 16'hFFFF) ? r_cycles : r_cycles + 16'd1;

`ifdef PRELOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum, w_sum_next;

  always_comb begin
    w_sum_next = r_sum;
    if (w_launch) begin
      w_sum_next = '0;
    end else if (r_state == StWrite && MFC) begin
      w_sum_next = r_sum + r_wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_sum_next;
    end
  end

  assign w_sum_ok = (r_sum == expected_sum);
`else
  logic w_unused_sum;
  assign w_unused_sum = ^expected_sum;
  assign w_sum_ok     = 1'b1;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_mem_addr_next = r_mem_addr;
    w_wdata_next    = r_wdata;
    w_tmo_next      = r_tmo;
    w_hold_next     = r_hold;
    w_cycles_next   = r_cycles;
    unique case (r_state)
      StIdle: ;
      StFetch: begin
        w_state_next    = StWrite;
        w_wdata_next    = src_data;
        w_mem_addr_next = {r_idx, 2'b00};
        w_tmo_next      = '0;
      end
      StWrite: begin
        if (MFC) begin
          w_state_next = StAckLow;
          w_tmo_next   = '0;
        end else if (r_tmo == 16'(MFC_TIMEOUT - 1)) begin
          w_state_next = StError;
        end else begin
          w_tmo_next = r_tmo + 16'd1;
        end
      end
      StAckLow: begin
        if (!MFC) begin
          if (w_last) begin
            w_state_next = w_sum_ok ? StHold : StError;
            w_hold_next  = '0;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_state_next = StFetch;
          end
        end else if (r_tmo == 16'(MFC_TIMEOUT - 1)) begin
          w_state_next = StError;
        end else begin
          w_tmo_next = r_tmo + 16'd1;
        end
      end
      StHold: begin
        if (r_hold == 16'(RST_HOLD - 1)) begin
          w_state_next = StRun;
        end else begin
          w_hold_next = r_hold + 16'd1;
        end
      end
      StRun: begin
        w_cycles_next = w_cyc_inc;
        if (32'(w_cyc_inc) == RUN_CYCLES) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_cycles_next = w_cyc_inc;
      StError: ;
      default: w_state_next = StIdle;
    endcase
    // Restart from IDLE, DONE or ERROR; busy states ignore start.
    if (w_launch) begin
      w_state_next  = StFetch;
      w_idx_next    = '0;
      w_cycles_next = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_mem_addr   <= '0;
      r_wdata      <= '0;
      r_tmo        <= '0;
      r_hold       <= '0;
      r_cycles     <= '0;
      r_mfa        <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_mem_addr   <= w_mem_addr_next;
      r_wdata      <= w_wdata_next;
      r_tmo        <= w_tmo_next;
      r_hold       <= w_hold_next;
      r_cycles     <= w_cycles_next;
      // Strobes decode the next state so every output comes straight from a flop.
      r_mfa        <= (w_state_next == StWrite);
      r_core_rst_n <= (w_state_next == StRun) || (w_state_next == StDone);
      r_busy       <= w_state_next inside {StFetch, StWrite, StAckLow, StHold, StRun};
      r_done       <= (w_state_next == StDone);
      r_err        <= (w_state_next == StError);
    end
  end

  assign src_addr     = r_idx;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_wdata;
  assign MFA          = r_mfa;
  assign core_reset_n = r_core_rst_n;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign cycles       = r_cycles;

endmodule

// File: tb/tb_sparc_preload_sequencer.sv
// Directed bench for sparc_preload_sequencer: WORDS=4 load/run, timeouts, mid-load reset,
// start handling and the optional image checksum.
module tb_sparc_preload_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src_addr;
  logic [31:0] src_data;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mfa;
  logic        mfc = 1'b0;
  logic        core_reset_n, busy, done, err;
  logic [15:0] cycles;
  logic [31:0] expected_sum = 32'h0;

  logic [31:0] img [4];
  int          n_checks = 0;
  int          n_errors = 0;

  // MFC responder modes, written only by the stimulus process.
  int          mfc_delay = 1;
  bit          mfc_never = 1'b0;
  bit          mfc_stuck = 1'b0;
  // Responder-owned state and write log.
  bit          stuck_latch = 1'b0;
  int          age = 0;
  int          wr_count = 0;
  logic [9:0]  log_addr [64];
  logic [31:0] log_data [64];

  sparc_preload_sequencer #(
    .DATA_W(32), .ADDR_W(8), .WORDS(4), .RUN_CYCLES(100), .MFC_TIMEOUT(15), .RST_HOLD(2)
  ) dut (
    .Clk(clk), .Reset(rst_n), .start(start), .src_addr(src_addr), .src_data(src_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .MFA(mfa), .MFC(mfc),
    .core_reset_n(core_reset_n), .busy(busy), .done(done), .err(err), .cycles(cycles),
    .expected_sum(expected_sum)
  );

  always #5 clk = ~clk;

  always_comb src_data = img[src_addr[1:0]];

  always @(posedge clk) begin
    #1;
    if (!mfc_stuck) stuck_latch = 1'b0;
    if (mfa && !mfc) begin
      age++;
      if (!mfc_never && age > mfc_delay) begin
        mfc = 1'b1;
        log_addr[wr_count % 64] = mem_addr;
        log_data[wr_count % 64] = mem_wdata;
        wr_count++;
        if (mfc_stuck) stuck_latch = 1'b1;
      end
    end else begin
      age = 0;
      mfc = stuck_latch;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Counts edges from the start pulse until the core is released or an error is flagged.
  task automatic run_to_release(output int n);
    pulse_start();
    n = 1;
    while (!core_reset_n && !err && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, m, base;
    bit mfa_seen;
    logic [31:0] sum;
    img[0] = 32'h9C044012;
    img[1] = 32'h12345678;
    img[2] = 32'hDEADBEEF;
    img[3] = 32'h00000001;
    sum = 32'h0;
    for (int i = 0; i < 4; i++) sum = sum + img[i];

    // Reset state
    tick();
    check_eq("rst_outputs", {src_addr, mem_addr, mfa, core_reset_n, busy, done, err, cycles},
             '0);
    check_eq("rst_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Load with 1-cycle MFC latency, start ignored during RUN
    base = wr_count;
    run_to_release(n);
    check_eq("release_lat", n, 19);
    check_eq("load_writes", wr_count - base, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ram_addr%0d", i), log_addr[(base + i) % 64], 10'(4 * i));
      check_eq($sformatf("ram_data%0d", i), log_data[(base + i) % 64], img[i]);
    end
    check_eq("run_entry", {cycles, busy, done, err}, {16'd0, 3'b100});
    m = 0;
    while (!done && m < 300) begin
      start = (m == 10);
      tick();
      m++;
    end
    start = 1'b0;
    check_eq("done_lat", m, 100);
    check_eq("done_cycles", cycles, 16'd100);
    check_eq("no_rewrite", wr_count - base, 4);
    repeat (5) tick();
    check_eq("done_count", {cycles, done, core_reset_n, busy}, {16'd105, 3'b110});

    // start in DONE reloads cleanly; MFC immediate gives the minimum timing
    mfc_delay = 0;
    base = wr_count;
    pulse_start();
    check_eq("restart_state", {cycles, done, busy, core_reset_n}, {16'd0, 3'b010});
    n = 1;
    while (!core_reset_n && n < 300) begin
      tick();
      n++;
    end
    check_eq("min_release_lat", n, 15);
    check_eq("reload_first_addr", log_addr[base % 64], 10'd0);

    // Reset during WRITE of word 2
    mfc_delay = 1;
    do_reset();
    base = wr_count;
    pulse_start();
    n = 0;
    while (!(mfa && mem_addr == 10'd8) && n < 200) begin
      tick();
      n++;
    end
    check_eq("reach_word2", mfa && mem_addr == 10'd8, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_abort", {src_addr, mem_addr, mfa, core_reset_n, busy, done, err, cycles},
             '0);
    check_eq("async_wdata", mem_wdata, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    base = wr_count;
    run_to_release(n);
    check_eq("reload_word0", {log_addr[base % 64], log_data[base % 64]}, {10'd0, img[0]});

    // MFC never answers
    do_reset();
    mfc_never = 1'b1;
    pulse_start();
    n = 0;
    while (!mfa && n < 50) begin
      tick();
      n++;
    end
    n = 0;
    while (!err && n < 100) begin
      tick();
      n++;
    end
    check_eq("write_tmo_lat", n, 15);
    check_eq("write_tmo_out", {mfa, core_reset_n, busy, done}, 4'b0000);
    mfc_never = 1'b0;

    // MFC stuck high after the first ack; start in ERROR restarts and clears err
    mfc_stuck = 1'b1;
    tick();
    pulse_start();
    check_eq("err_cleared", {err, busy}, 2'b01);
    n = 0;
    while (!mfa && n < 50) begin
      tick();
      n++;
    end
    while (mfa && n < 100) begin
      tick();
      n++;
    end
    n = 0;
    mfa_seen = 1'b0;
    while (!err && n < 100) begin
      tick();
      n++;
      if (mfa) mfa_seen = 1'b1;
    end
    check_eq("ack_tmo_lat", n, 15);
    check_eq("ack_tmo_no_mfa", mfa_seen, 1'b0);
    check_eq("ack_tmo_out", {err, core_reset_n}, 2'b10);
    mfc_stuck = 1'b0;
    tick();
    tick();

    // Image checksum: off by one, then correct
    mfc_delay = 0;
    do_reset();
    expected_sum = sum + 32'd1;
    run_to_release(n);
`ifdef PRELOAD_CHECKSUM_EN
    check_eq("sum_bad", {err, core_reset_n}, 2'b10);
`else
    check_eq("sum_ignored", {err, core_reset_n}, 2'b01);
    check_eq("sum_ignored_lat", n, 15);
`endif
    do_reset();
    expected_sum = sum;
    run_to_release(n);
    check_eq("sum_good", {err, core_reset_n}, 2'b01);
    check_eq("sum_good_lat", n, 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
